// File: rtl/lif_scheduler.sv
// Timestep scheduler for a layer of LIF neurons: streams currents into a 1-cycle LIF datapath
// and writes results back. Optional spike events enabled by LIF_SCHED_SPIKE_EVT_EN.
module lif_scheduler #(
    parameter int unsigned N_NEURON    = 16,
    parameter int unsigned IDX_WIDTH   = 4,
    parameter int unsigned MEM_WIDTH   = 24,
    parameter int unsigned IN_WIDTH    = 18,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clr,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                ts_count,
    input  logic                       cur_valid,
    output logic                       cur_ready,
    input  logic signed [IN_WIDTH-1:0] cur_data,
    output logic                       lif_valid_in,
    output logic [IN_WIDTH-1:0]        lif_i_in,
    output logic [MEM_WIDTH-1:0]       lif_v_old,
    output logic [COUNT_WIDTH-1:0]     lif_cnt_old,
    input  logic                       lif_valid_out,
    input  logic [MEM_WIDTH-1:0]       lif_v_new,
    input  logic [COUNT_WIDTH-1:0]     lif_cnt_new,
    output logic                       spike_valid,
    output logic [IDX_WIDTH-1:0]       spike_idx,
    input  logic [IDX_WIDTH-1:0]       rd_idx,
    output logic [MEM_WIDTH-1:0]       rd_v,
    output logic [COUNT_WIDTH-1:0]     rd_cnt
);

    localparam int unsigned AW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(N_NEURON - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   issue_idx_q, wb_idx_q;
    logic                   wb_pending_q;
    logic [15:0]            ts_count_q;
    logic [MEM_WIDTH-1:0]   v_mem_q   [N_NEURON];
    logic [COUNT_WIDTH-1:0] cnt_mem_q [N_NEURON];

    logic transfer, wb_fire, start_ok, clr_ok;

    assign transfer = cur_valid & cur_ready;
    // Writebacks are accepted only one cycle after an issue (fixed datapath latency).
    assign wb_fire  = lif_valid_out & wb_pending_q;
    assign clr_ok   = (state_q == StIdle) & clr;
    assign start_ok = (state_q == StIdle) & start & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StIssue;
            StIssue: if (transfer && issue_idx_q == LastIdx) state_d = StDrain;
            StDrain: if (wb_fire && wb_idx_q == LastIdx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        cur_ready = (state_q == StIssue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_idx_q  <= '0;
            wb_idx_q     <= '0;
            wb_pending_q <= 1'b0;
            ts_count_q   <= '0;
        end else begin
            wb_pending_q <= transfer;
            if (start_ok) begin
                issue_idx_q <= '0;
            end else if (transfer) begin
                issue_idx_q <= issue_idx_q + 1'b1;
            end
            if (transfer) begin
                wb_idx_q <= issue_idx_q;
            end
            if (state_q == StDone) begin
                ts_count_q <= ts_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_ok) begin
            for (int i = 0; i < N_NEURON; i++) begin
                v_mem_q[i]   <= '0;
                cnt_mem_q[i] <= '0;
            end
        end else if (wb_fire) begin
            v_mem_q[wb_idx_q[AW-1:0]]   <= lif_v_new;
            cnt_mem_q[wb_idx_q[AW-1:0]] <= lif_cnt_new;
        end
    end

    assign ts_count     = ts_count_q;
    assign lif_valid_in = transfer;
    assign lif_i_in     = cur_data;
    assign lif_v_old    = v_mem_q[issue_idx_q[AW-1:0]];
    assign lif_cnt_old  = cnt_mem_q[issue_idx_q[AW-1:0]];

    always_comb begin
        rd_v   = '0;
        rd_cnt = '0;
        if (32'(rd_idx) < N_NEURON) begin
            rd_v   = v_mem_q[rd_idx[AW-1:0]];
            rd_cnt = cnt_mem_q[rd_idx[AW-1:0]];
        end
    end

`ifdef LIF_SCHED_SPIKE_EVT_EN
    logic                 spike_valid_q, spike_evt;
    logic [IDX_WIDTH-1:0] spike_idx_q;

    // A changed spike count on writeback means the neuron fired this timestep.
    assign spike_evt = wb_fire & (lif_cnt_new != cnt_mem_q[wb_idx_q[AW-1:0]]);

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
        end else begin
            spike_valid_q <= spike_evt;
            spike_idx_q   <= spike_evt ? wb_idx_q : '0;
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
`else
    assign spike_valid = 1'b0;
    assign spike_idx   = '0;
`endif

endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler with a 1-cycle LIF datapath (V_TH=1000, TAU_SHIFT=2, 4 neurons).
module tb_lif_scheduler;

    localparam int N   = 4;
    localparam int IW  = 3;
    localparam int MW  = 24;
    localparam int INW = 18;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst, start, clr, busy, done, cur_valid, cur_ready;
    logic [15:0] ts_count;
    logic signed [INW-1:0] cur_data;
    logic lif_valid_in, lif_valid_out, spike_valid;
    logic [INW-1:0] lif_i_in;
    logic [MW-1:0] lif_v_old, lif_v_new, rd_v;
    logic [CW-1:0] lif_cnt_old, lif_cnt_new, rd_cnt;
    logic [IW-1:0] spike_idx, rd_idx;

    always #5 clk = ~clk;

    lif_scheduler #(
        .N_NEURON(N), .IDX_WIDTH(IW), .MEM_WIDTH(MW), .IN_WIDTH(INW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .busy(busy), .done(done),
        .ts_count(ts_count), .cur_valid(cur_valid), .cur_ready(cur_ready),
        .cur_data(cur_data), .lif_valid_in(lif_valid_in), .lif_i_in(lif_i_in),
        .lif_v_old(lif_v_old), .lif_cnt_old(lif_cnt_old), .lif_valid_out(lif_valid_out),
        .lif_v_new(lif_v_new), .lif_cnt_new(lif_cnt_new), .spike_valid(spike_valid),
        .spike_idx(spike_idx), .rd_idx(rd_idx), .rd_v(rd_v), .rd_cnt(rd_cnt)
    );

    // Leak by v>>>2, integrate, fire at 1000 with subtractive reset.
    function automatic int lif_step(input int v, input int i, output bit sp);
        int s;
        s  = v - (v >>> 2) + i;
        sp = (s >= 1000);
        return sp ? s - 1000 : s;
    endfunction

    int dp_nv;
    bit dp_sp;
    always_comb begin
        dp_sp = 1'b0;
        dp_nv = lif_step(int'($signed(lif_v_old)), int'($signed(lif_i_in)), dp_sp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lif_valid_out <= 1'b0;
            lif_v_new     <= '0;
            lif_cnt_new   <= '0;
        end else begin
            lif_valid_out <= lif_valid_in;
            lif_v_new     <= MW'(dp_nv);
            lif_cnt_new   <= lif_cnt_old + CW'(dp_sp);
        end
    end

    typedef struct {int v; int i;} iss_t;
    iss_t iss_q[$];
    int   spk_q[$];
    iss_t mon_e;
    int   ref_v[N], ref_cnt[N];
    int   checks = 0, passes = 0;
    int   cyc = 0, first_iss = -1, last_iss = -1, done_cnt = 0, spike_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) begin
            passes = passes + 1;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (lif_valid_in) begin
            check("issue_expected", 32'(iss_q.size() != 0), 1);
            if (iss_q.size() != 0) begin
                mon_e = iss_q.pop_front();
                check("lif_v_old", 32'(lif_v_old), mon_e.v);
                check("lif_i_in", 32'(lif_i_in), mon_e.i);
            end
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
        end
        if (done) done_cnt = done_cnt + 1;
        if (spike_valid) begin
`ifdef LIF_SCHED_SPIKE_EVT_EN
            check("spike_expected", 32'(spk_q.size() != 0), 1);
            if (spk_q.size() != 0) check("spike_idx", 32'(spike_idx), spk_q.pop_front());
`else
            spike_seen = spike_seen + 1;
`endif
        end
    end

    task automatic feed(input int k, input int c);
        bit sp;
        int nv;
        nv = lif_step(ref_v[k], c, sp);
        iss_q.push_back('{ref_v[k], c});
`ifdef LIF_SCHED_SPIKE_EVT_EN
        if (sp) spk_q.push_back(k);
`endif
        ref_v[k]   = nv;
        ref_cnt[k] = ref_cnt[k] + int'(sp);
        cur_valid  = 1'b1;
        cur_data   = INW'(c);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cur_ready) break;
        end
        check("cur_ready", 32'(cur_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_pulse", 32'(done), 1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 0);
    endtask

    task automatic run_ts(input int c, input int gap_at, input int gap_len, input int poke_at);
        first_iss = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == gap_at) begin
                cur_valid = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            if (k == poke_at) begin
                start = 1'b1;
                clr   = 1'b1;
            end
            feed(k, c);
            start = 1'b0;
            clr   = 1'b0;
        end
        cur_valid = 1'b0;
        wait_done();
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < N; k++) begin
            rd_idx = IW'(k);
            #1;
            check({tag, "_rd_v"}, 32'(rd_v), ref_v[k]);
            check({tag, "_rd_cnt"}, 32'(rd_cnt), ref_cnt[k] % (1 << CW));
        end
    endtask

    task automatic zero_ref();
        for (int k = 0; k < N; k++) begin
            ref_v[k]   = 0;
            ref_cnt[k] = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; cur_valid = 1'b0; cur_data = '0; rd_idx = '0;
        zero_ref();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cur_ready", 32'(cur_ready), 0);
        check("rst_lif_valid_in", 32'(lif_valid_in), 0);
        check("rst_spike_valid", 32'(spike_valid), 0);
        check("rst_spike_idx", 32'(spike_idx), 0);
        check("rst_ts_count", 32'(ts_count), 0);
        check_state("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_ts(1200, -1, 0, -1);
        check("ts1_span", 32'(last_iss - first_iss), 3);
        check("ts1_count", 32'(ts_count), 1);
        check("ts1_done_cnt", 32'(done_cnt), 1);
        check_state("ts1");

        run_ts(0, -1, 0, -1);
        check("ts2_count", 32'(ts_count), 2);
        check_state("ts2");

        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        zero_ref();
        @(negedge clk);
        check("clr_busy", 32'(busy), 0);
        check_state("clr");

        run_ts(1200, 2, 3, -1);
        check("gap_span", 32'(last_iss - first_iss), 6);
        check("gap_count", 32'(ts_count), 3);
        check_state("gap");

        run_ts(0, -1, 0, 1);
        check("poke_count", 32'(ts_count), 4);
        check("poke_done_cnt", 32'(done_cnt), 4);
        check_state("poke");

        start = 1'b1;
        clr   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clr   = 1'b0;
        zero_ref();
        @(negedge clk);
        check("clrstart_busy0", 32'(busy), 0);
        @(negedge clk);
        check("clrstart_busy1", 32'(busy), 0);
        check_state("clrstart");

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed(0, 1200);
        feed(1, 1200);
        rst       = 1'b1;
        cur_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        spk_q.delete();
        zero_ref();
        repeat (10) @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done_cnt", 32'(done_cnt), 4);
        check("abort_ts_count", 32'(ts_count), 0);
        check_state("abort");

        run_ts(1200, -1, 0, -1);
        check("rerun_count", 32'(ts_count), 1);
        check("rerun_done_cnt", 32'(done_cnt), 5);
        check_state("rerun");

        rd_idx = IW'(5);
        #1;
        check("oob_rd_v", 32'(rd_v), 0);
        check("oob_rd_cnt", 32'(rd_cnt), 0);

        repeat (3) @(negedge clk);
        check("iss_q_empty", 32'(iss_q.size()), 0);
        check("spk_q_empty", 32'(spk_q.size()), 0);
        check("spike_never_when_disabled", 32'(spike_seen), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_NEURON, 16: neurons per layer.
- IDX_WIDTH, 4: neuron index width; 2^IDX_WIDTH >= N_NEURON.
- MEM_WIDTH, 24: membrane width.
- IN_WIDTH, 18: current width.
- COUNT_WIDTH, 4: spike-count width.
REQ-002 Ports SHALL be (name, direction, width, meaning); clock is clk, reset is rst, one clock domain, reset synchronous and active-high:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: begin one timestep.
- clr, in, 1: zero all neuron state.
- busy, out, 1: timestep in progress.
- done, out, 1: one-cycle timestep-complete pulse.
- ts_count, out, 16: completed-timestep counter.
- cur_valid, in, 1: input-current handshake valid.
- cur_ready, out, 1: input-current handshake ready.
- cur_data, in, IN_WIDTH signed: current for the next neuron in index order.
- lif_valid_in, out, 1: issue strobe to the LIF datapath.
- lif_i_in, out, IN_WIDTH: current issued to the LIF datapath.
- lif_v_old, out, MEM_WIDTH: stored membrane of the issued neuron.
- lif_cnt_old, out, COUNT_WIDTH: stored spike count of the issued neuron.
- lif_valid_out, in, 1: LIF result valid.
- lif_v_new, in, MEM_WIDTH: updated membrane.
- lif_cnt_new, in, COUNT_WIDTH: updated spike count.
- spike_valid, out, 1: spike event strobe.
- spike_idx, out, IDX_WIDTH: index of the spiking neuron.
- rd_idx, in, IDX_WIDTH: state readout index.
- rd_v, out, MEM_WIDTH: combinational read of v_mem[rd_idx].
- rd_cnt, out, COUNT_WIDTH: combinational read of cnt_mem[rd_idx].

Function
REQ-003 State storage SHALL be internal register arrays v_mem[N_NEURON] and cnt_mem[N_NEURON].
REQ-004 FSM SHALL have states IDLE, ISSUE, DRAIN, DONE; busy=1 in any state except IDLE.
REQ-005 In IDLE, start=1 with clr=0 SHALL go to ISSUE with issue_idx=0; start SHALL be ignored in any other state.
REQ-006 In IDLE, clr=1 SHALL zero all v_mem/cnt_mem in one cycle; clr wins over a simultaneous start, and the start is dropped; clr outside IDLE SHALL be ignored.
REQ-007 cur_ready SHALL equal (state==ISSUE); transfer = cur_valid & cur_ready.
REQ-008 On transfer, combinationally, same cycle: lif_valid_in=1, lif_i_in=cur_data, lif_v_old=v_mem[issue_idx], lif_cnt_old=cnt_mem[issue_idx]; otherwise lif_valid_in=0.
REQ-009 On transfer, wb_idx SHALL be set to issue_idx and issue_idx SHALL increment; the transfer at issue_idx=N_NEURON-1 SHALL move the FSM to DRAIN.
REQ-010 The LIF datapath latency is fixed at 1 cycle; on lif_valid_out=1, v_mem[wb_idx]<=lif_v_new and cnt_mem[wb_idx]<=lif_cnt_new; back-to-back issue/writeback of different indices SHALL be supported.
REQ-011 In DRAIN, the writeback of index N_NEURON-1 SHALL move the FSM to DONE; DONE SHALL last exactly one cycle with done=1, increment ts_count (wrapping 65535->0), then return to IDLE.
REQ-012 lif_valid_out while not expecting a writeback SHALL be ignored (no state write).
REQ-013 rd_v/rd_cnt SHALL reflect stored values; a write in cycle t is visible from cycle t+1; rd_idx >= N_NEURON SHALL return 0.

Reset
REQ-014 rst=1 at a clock edge SHALL force IDLE, issue_idx=0, wb_idx=0, ts_count=0, all v_mem/cnt_mem=0, and done=0, spike_valid=0, spike_idx=0, cur_ready=0, lif_valid_in=0.
REQ-015 Reset mid-timestep SHALL abort it with no done pulse and no further writebacks.

Configuration
REQ-016 With macro LIF_SCHED_SPIKE_EVT_EN defined: on each writeback where lif_cnt_new != cnt_mem[wb_idx] (pre-write value), registered spike_valid=1 and spike_idx=wb_idx SHALL appear the next cycle for one cycle.
REQ-017 Without LIF_SCHED_SPIKE_EVT_EN: spike_valid and spike_idx SHALL be constant 0, the ports SHALL remain, and no comparison logic is present.

Verification
Bench pairs the block with a 1-cycle LIF datapath configured with V_TH=1000, TAU_SHIFT=2, N_NEURON=4.
REQ-018 After reset, start, 4 currents of 1200 with cur_valid held high -> 4 issues in consecutive cycles; all rd_v=200 and rd_cnt=1; spikes idx 0,1,2,3 (EVT_EN); one done pulse; ts_count=1.
REQ-019 Next timestep, all currents 0 -> rd_v=150, rd_cnt=1, no spike_valid, ts_count=2.
REQ-020 cur_valid deasserted 3 cycles between neurons 1 and 2 -> no lif_valid_in during the gap; final state identical to REQ-018.
REQ-021 start while busy and clr while busy -> both ignored; clr+start together in IDLE -> state zeroed, busy stays 0.
REQ-022 rst asserted after 2 issues -> busy=0, no done, all rd_v=0, ts_count=0; a following start completes normally.
REQ-023 Undefined LIF_SCHED_SPIKE_EVT_EN and rerun REQ-018 -> spike_valid never 1; state results unchanged.
